// File: rtl/nibble_serial_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor that reuses one 4-bit add/sub slice,
// processing one nibble per cycle (LSB first) and rippling the carry in a register.
module nibble_serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             y
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             m_q, m_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             y_q, y_d;

    logic [3:0] a_nib;
    logic [3:0] b_nib;
    logic [4:0] slice_sum;
    logic       c3;

    // The shared slice: b is inverted in subtract mode, carry_q supplies the +1.
    always_comb begin
        a_nib     = a_q[4*idx_q +: 4];
        b_nib     = b_q[4*idx_q +: 4] ^ {4{m_q}};
        slice_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
        // Carry into bit 3 recovered from the bit-3 sum: sum = a ^ b ^ cin.
        c3        = a_nib[3] ^ b_nib[3] ^ slice_sum[3];
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        s_d     = s_q;
        cout_d  = cout_q;
        y_d     = y_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    m_d     = m;
                    carry_d = m;
                    idx_d   = '0;
                    s_d     = '0;
                    cout_d  = 1'b0;
                    y_d     = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                s_d[4*idx_q +: 4] = slice_sum[3:0];
                carry_d           = slice_sum[4];
                if (idx_q == IDX_W'(NIB - 1)) begin
                    cout_d  = slice_sum[4];
                    y_d     = slice_sum[4] ^ c3;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            y_q     <= y_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign s     = s_q;
    assign cout  = cout_q;
    assign y     = y_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench for nibble_serial_addsub at WIDTH=16 and WIDTH=4:
// directed vector table, handshake/reset corner sequences, random vs. flat model.
module tb_nibble_serial_addsub;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start16 = 1'b0, m16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ready16, busy16, done16, cout16, y16;
    logic [15:0] s16;

    logic        start4 = 1'b0, m4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        ready4, busy4, done4, cout4, y4;
    logic [3:0]  s4;

    nibble_serial_addsub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .m(m16),
        .ready(ready16), .busy(busy16), .done(done16), .s(s16), .cout(cout16), .y(y16)
    );

    nibble_serial_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .m(m4),
        .ready(ready4), .busy(busy4), .done(done4), .s(s4), .cout(cout4), .y(y4)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Flat two's-complement reference: plain integer add and sign-rule overflow.
    task automatic ref_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic m,
                          output logic [15:0] rs, output logic rc, output logic ry);
        int unsigned mask, bx, sum;
        logic sa, sb, sr;
        mask = (32'd1 << w) - 1;
        bx   = (m ? ~{16'h0, b} : {16'h0, b}) & mask;
        sum  = ({16'h0, a} & mask) + bx + (m ? 1 : 0);
        rs   = 16'(sum & mask);
        rc   = sum[w];
        sa   = a[w-1];
        sb   = bx[w-1];
        sr   = rs[w-1];
        ry   = (sa == sb) && (sr != sa);
    endtask

    // Accept one operation on the selected DUT and wait (bounded) for done.
    // lat = number of rising edges from the accept edge through the edge that raises done.
    task automatic do_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic m,
                         output logic [15:0] rs, output logic rc, output logic ry, output int lat);
        logic dn;
        if (w == 16) begin a16 = a; b16 = b; m16 = m; start16 = 1'b1; end
        else begin a4 = a[3:0]; b4 = b[3:0]; m4 = m; start4 = 1'b1; end
        @(posedge clk); #1;
        start16 = 1'b0; start4 = 1'b0;
        lat = 1;
        dn  = (w == 16) ? done16 : done4;
        while (!dn && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            dn = (w == 16) ? done16 : done4;
        end
        if (!dn) begin
            errors++;
            checks++;
            $display("FAIL timeout w=%0d: done never rose within 20 cycles", w);
        end
        if (w == 16) begin rs = s16; rc = cout16; ry = y16; end
        else begin rs = {12'h0, s4}; rc = cout4; ry = y4; end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        m;
        logic [15:0] es;
        logic        ec;
        logic        ey;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [15:0] gs, es;
        logic        gc, gy, ec, ey;
        int          lat, ndone;

        vecs[0] = '{16'h1234, 16'h0FF1, 1'b0, 16'h2225, 1'b0, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", ready16, 1);
        check("reset_busy", busy16, 0);
        check("reset_done", done16, 0);
        check("reset_s", s16, 0);
        check("reset_cout", cout16, 0);
        check("reset_y", y16, 0);
        check("reset_ready4", ready4, 1);
        rst = 1'b0;

        // Directed vectors: result, flags, latency, and ready right after done.
        for (int i = 0; i < 6; i++) begin
            do_op(16, vecs[i].a, vecs[i].b, vecs[i].m, gs, gc, gy, lat);
            check($sformatf("vec%0d_s", i), gs, vecs[i].es);
            check($sformatf("vec%0d_cout", i), gc, vecs[i].ec);
            check($sformatf("vec%0d_y", i), gy, vecs[i].ey);
            check($sformatf("vec%0d_latency", i), lat, 5);
            check($sformatf("vec%0d_ready_in_done", i), ready16, 0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_ready_after", i), ready16, 1);
            check($sformatf("vec%0d_s_hold", i), s16, vecs[i].es);
        end

        // start held and operands changed while the operation is in flight.
        a16 = 16'h0001; b16 = 16'h0001; m16 = 1'b0; start16 = 1'b1;
        @(posedge clk); #1;
        a16 = 16'hAAAA; b16 = 16'h5555; m16 = 1'b1;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            if (done16) begin
                ndone++;
                check("hold_s", s16, 16'h0002);
                start16 = 1'b0;
            end
            @(posedge clk); #1;
        end
        start16 = 1'b0;
        check("hold_one_done", ndone, 1);
        check("hold_idle", ready16, 1);
        check("hold_s_kept", s16, 16'h0002);

        // rst on the second RUN cycle aborts the operation.
        a16 = 16'h1111; b16 = 16'h2222; m16 = 1'b0; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        @(posedge clk); #1;
        check("abort_busy_before", busy16, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_ready", ready16, 1);
        check("abort_busy", busy16, 0);
        check("abort_s", s16, 0);
        check("abort_cout", cout16, 0);
        check("abort_y", y16, 0);
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            if (done16) ndone++;
            @(posedge clk); #1;
        end
        check("abort_no_done", ndone, 0);
        do_op(16, 16'h0003, 16'h0004, 1'b0, gs, gc, gy, lat);
        check("abort_next_s", gs, 16'h0007);
        @(posedge clk); #1;

        // rst and start together: rst wins.
        a16 = 16'h00FF; b16 = 16'h0001; start16 = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start16 = 1'b0;
        check("rst_start_ready", ready16, 1);
        check("rst_start_busy", busy16, 0);

        // Random regression against the flat model at both widths.
        for (int w = 4; w <= 16; w += 12) begin
            for (int i = 0; i < 1000; i++) begin
                logic [15:0] ra, rb;
                logic        rm;
                ra = 16'($urandom);
                rb = 16'($urandom);
                rm = 1'($urandom);
                if (w == 4) begin ra[15:4] = '0; rb[15:4] = '0; end
                ref_op(w, ra, rb, rm, es, ec, ey);
                do_op(w, ra, rb, rm, gs, gc, gy, lat);
                check($sformatf("rnd%0d_%0d_s a=%h b=%h m=%0d", w, i, ra, rb, rm), gs, es);
                check($sformatf("rnd%0d_%0d_cout", w, i), gc, ec);
                check($sformatf("rnd%0d_%0d_y", w, i), gy, ey);
                if (i == 0) check($sformatf("rnd%0d_latency", w), lat, w / 4 + 1);
                @(posedge clk); #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
